// File: rtl/simple_codeword_checker.sv
`default_nettype none
// ============================================================================
// Module   : simple_codeword_checker
// Purpose  : Streaming checker placed after simple_encoder. Each codeword is
//            {data[DATA_W-1:0], check[CHK_W-1:0]}. The check field must equal
//            the low CHK_W bits of the data field. The data byte is passed
//            through uncorrected, together with an error flag, into a small
//            output FIFO behind a valid/ready handshake. Saturating word and
//            error counters are provided for status readout.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            in_valid/in_ready  - input handshake (in_ready is registered)
//            in_codeword        - {data, check}
//            out_valid/out_ready- output handshake, FIFO head
//            out_data/out_err   - head entry data byte and check-fail flag
//            word_count         - accepted codewords (saturating)
//            err_count          - accepted codewords failing check (saturating)
//            clear_counts       - synchronous clear of both counters
// Options  : CHECKER_HALT_ON_ERR_EN - when defined, an accepted erroneous word
//            halts the input side until clear_counts is pulsed.
// Revision : 1.0 - initial release
// ============================================================================
module simple_codeword_checker #(
    parameter int DATA_W = 8,
    parameter int CHK_W  = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W+CHK_W-1:0]   in_codeword,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_err,
    output logic [CNT_W-1:0]          word_count,
    output logic [CNT_W-1:0]          err_count,
    input  logic                      clear_counts
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_ADDR_W:0]   c_OCC_ONE  = 1;
    localparam logic [c_ADDR_W:0]   c_OCC_FULL = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = 1;
    localparam logic [CNT_W-1:0]    c_CNT_ONE  = 1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_W:0]       r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_ADDR_W:0]     r_count;
    logic [c_ADDR_W:0]     w_count_next;
    logic                  r_in_ready;
    logic [CNT_W-1:0]      r_word_count;
    logic [CNT_W-1:0]      r_err_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_err;

    // Check field against the low CHK_W bits of the data field.
    assign w_err  = (in_codeword[CHK_W-1:0] != in_codeword[2*CHK_W-1:CHK_W]);
    assign w_push = in_valid && r_in_ready;
    assign w_pop  = out_valid && out_ready;

    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_rd_ptr][DATA_W:1];
    assign out_err    = r_mem[r_rd_ptr][0];
    assign in_ready   = r_in_ready;
    assign word_count = r_word_count;
    assign err_count  = r_err_count;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_OCC_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_OCC_ONE;
        end
    end

`ifdef CHECKER_HALT_ON_ERR_EN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (w_push && w_err) w_state_next = ST_HALT;
            ST_HALT: if (clear_counts)    w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end
`else
    // Without the halt option the FSM holds its reset state (RUN) forever.
    assign w_state_next = r_state;
`endif

    // FSM, FIFO pointers/occupancy and registered in_ready. in_ready is
    // derived from next-state values so it never depends combinationally
    // on out_ready; a pop while full only raises it on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != c_OCC_FULL) && (w_state_next == ST_RUN);
            if (w_push) begin
                r_mem[r_wr_ptr] <= {in_codeword[DATA_W+CHK_W-1:CHK_W], w_err};
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Saturating counters. A clear coinciding with an accept keeps only the
    // contribution of that word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_count <= '0;
            r_err_count  <= '0;
        end else if (clear_counts) begin
            r_word_count <= w_push ? c_CNT_ONE : '0;
            r_err_count  <= (w_push && w_err) ? c_CNT_ONE : '0;
        end else if (w_push) begin
            if (r_word_count != '1) begin
                r_word_count <= r_word_count + c_CNT_ONE;
            end
            if (w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire
